// File: rtl/cnn_argmax_if.sv
// Handshake and BRAM read-port bundle between the FC2 argmax stage and its controller.
// The slave side is the argmax block; the master side drives start, grant and read data.
interface cnn_argmax_if #(
  parameter int width      = 16,
  parameter int memaddrbit = 20,
  parameter int idxbit     = 4
);
  logic                  start;
  logic                  rd_gnt;
  logic                  rd_en;
  logic [memaddrbit-1:0] rd_addr;
  logic [width-1:0]      rd_data;
  logic                  busy;
  logic                  done;
  logic [idxbit-1:0]     class_idx;
  logic [width-1:0]      class_score;

  modport master (
    output start, rd_gnt, rd_data,
    input  rd_en, rd_addr, busy, done, class_idx, class_score
  );

  modport slave (
    input  start, rd_gnt, rd_data,
    output rd_en, rd_addr, busy, done, class_idx, class_score
  );
endinterface

// File: rtl/cnn_argmax.sv
// Post-FC2 classifier: scans num_class signed scores from the shared activation BRAM
// and reports the index and value of the largest one (ties keep the lowest index).
module cnn_argmax #(
  parameter int width      = 16,
  parameter int decimal    = 12,
  parameter int memaddrbit = 20,
  parameter int num_class  = 10,
  parameter int base_addr  = 572414,
  parameter int rd_lat     = 2,
  parameter int idxbit     = 4
) (
  input logic         clk,
  input logic         rst,
  cnn_argmax_if.slave bus
);

  localparam int CW = $clog2(num_class + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0]         NUM_C  = CW'(num_class);
  localparam logic [CW-1:0]         LAST_C = CW'(num_class - 1);
  localparam logic [CW-1:0]         ZERO_C = CW'(0);
  localparam logic [CW-1:0]         ONE_C  = CW'(1);
  localparam logic [memaddrbit-1:0] BASE_A = memaddrbit'(base_addr);
  localparam logic [memaddrbit-1:0] ONE_A  = memaddrbit'(1);

  // decimal only documents the Q format; scores are compared as raw signed words
  if (decimal >= width) begin : g_decimal_exceeds_width
  end

  logic [1:0]               state_r;
  logic [CW-1:0]            issue_cnt_r;
  logic [CW-1:0]            recv_cnt_r;
  logic [memaddrbit-1:0]    rd_addr_r;
  logic [rd_lat-1:0]        vld_r;
  logic signed [width-1:0]  best_r;
  logic [idxbit-1:0]        best_idx_r;
  logic                     busy_r;
  logic                     done_r;
  logic [idxbit-1:0]        class_idx_r;
  logic [width-1:0]         class_score_r;

  logic                     rd_en_s;
  logic                     take_s;
  logic [width-1:0]         next_score_s;
  logic [idxbit-1:0]        next_idx_s;

  // Read strobe follows the grant combinationally; candidate best for the returning sample
  always_comb begin
    rd_en_s      = 1'b0;
    take_s       = 1'b0;
    next_score_s = best_r;
    next_idx_s   = best_idx_r;
    if ((state_r == READ) && bus.rd_gnt && (issue_cnt_r < NUM_C)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
    // first sample seeds the maximum so all-negative score sets work
    if ((recv_cnt_r == ZERO_C) || ($signed(bus.rd_data) > best_r)) begin
      take_s       = 1'b1;
      next_score_s = bus.rd_data;
      next_idx_s   = idxbit'(recv_cnt_r);
    end else begin
      take_s       = 1'b0;
      next_score_s = best_r;
      next_idx_s   = best_idx_r;
    end
  end

  // Scan FSM: issue reads, track returns through the valid pipe, publish the result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      issue_cnt_r   <= ZERO_C;
      recv_cnt_r    <= ZERO_C;
      rd_addr_r     <= '0;
      vld_r         <= '0;
      best_r        <= '0;
      best_idx_r    <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      class_idx_r   <= '0;
      class_score_r <= '0;
    end else begin
      vld_r[0] <= rd_en_s;
      for (int i = 1; i < rd_lat; i++) begin
        vld_r[i] <= vld_r[i-1];
      end
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r     <= READ;
            issue_cnt_r <= ZERO_C;
            recv_cnt_r  <= ZERO_C;
            rd_addr_r   <= BASE_A;
            busy_r      <= 1'b1;
          end
        end
        READ: begin
          if (rd_en_s) begin
            issue_cnt_r <= issue_cnt_r + ONE_C;
            // address parks on the last score instead of running past it
            if (issue_cnt_r < LAST_C) begin
              rd_addr_r <= rd_addr_r + ONE_A;
            end
          end
          if (vld_r[rd_lat-1]) begin
            recv_cnt_r <= recv_cnt_r + ONE_C;
            if (take_s) begin
              best_r     <= $signed(next_score_s);
              best_idx_r <= next_idx_s;
            end
            if (recv_cnt_r == LAST_C) begin
              state_r       <= DONE;
              done_r        <= 1'b1;
              class_idx_r   <= next_idx_s;
              class_score_r <= next_score_s;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_en       = rd_en_s;
  assign bus.rd_addr     = rd_addr_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.class_idx   = class_idx_r;
  assign bus.class_score = class_score_r;

endmodule

// File: tb/tb_cnn_argmax.sv
// Directed and randomized bench for cnn_argmax with a behavioural BRAM and an argmax
// reference computed directly over the score array.
module tb_cnn_argmax;

  localparam int W    = 16;
  localparam int AW   = 20;
  localparam int NC   = 10;
  localparam int BASE = 572414;
  localparam int RDL  = 2;
  localparam int IW   = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [W-1:0] mem [NC];
  logic [W-1:0] rdq [RDL];

  cnn_argmax_if #(.width(W), .memaddrbit(AW), .idxbit(IW)) bus ();

  cnn_argmax #(
    .width(W), .decimal(12), .memaddrbit(AW), .num_class(NC),
    .base_addr(BASE), .rd_lat(RDL), .idxbit(IW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM: data appears RDL cycles after the read strobe; out-of-range reads return a marker
  always @(posedge clk) begin
    if (bus.rd_en && (int'(bus.rd_addr) >= BASE) && (int'(bus.rd_addr) < BASE + NC))
      rdq[0] <= mem[int'(bus.rd_addr) - BASE];
    else
      rdq[0] <= 16'hDEAD;
    for (int i = 1; i < RDL; i++) rdq[i] <= rdq[i-1];
  end
  assign bus.rd_data = rdq[RDL-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_argmax(output int idx, output logic [W-1:0] score);
    int best;
    idx  = 0;
    best = int'($signed(mem[0]));
    for (int i = 1; i < NC; i++) begin
      if (int'($signed(mem[i])) > best) begin
        best = int'($signed(mem[i]));
        idx  = i;
      end
    end
    score = mem[idx];
  endtask

  // gnt_pat: 0 always granted, 1 alternating starting granted, 2 random
  task automatic classify(input string tag, input int gnt_pat, input bit extra_start);
    int           exp_idx;
    logic [W-1:0] exp_score;
    int           issued;
    int           last_issue;
    bit           seen;
    logic         g;
    ref_argmax(exp_idx, exp_score);
    issued     = 0;
    last_issue = 0;
    seen       = 1'b0;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 200 && !seen; cyc++) begin
      case (gnt_pat)
        0:       g = 1'b1;
        1:       g = (cyc % 2 == 1);
        default: g = 1'($urandom_range(0, 1));
      endcase
      bus.rd_gnt = g;
      bus.start  = extra_start && (cyc == 5 || (issued == NC && cyc == last_issue + RDL + 1));
      #1;
      chk({tag, ":busy"}, 32'(bus.busy), 32'd1);
      chk({tag, ":rd_en"}, 32'(bus.rd_en), 32'(g && issued < NC));
      if (bus.rd_en) begin
        chk({tag, ":rd_addr"}, 32'(bus.rd_addr), 32'(BASE + issued));
        issued++;
        last_issue = cyc;
      end
      if (bus.done) begin
        seen = 1'b1;
        chk({tag, ":done_cycle"}, 32'(cyc), 32'(last_issue + RDL + 1));
        chk({tag, ":reads"}, 32'(issued), 32'(NC));
        chk({tag, ":idx"}, 32'(bus.class_idx), 32'(exp_idx));
        chk({tag, ":score"}, 32'(bus.class_score), 32'(exp_score));
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk({tag, ":done_seen"}, 32'(seen), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk({tag, ":done_after"}, 32'(bus.done), 32'd0);
      chk({tag, ":busy_after"}, 32'(bus.busy), 32'd0);
      chk({tag, ":idx_held"}, 32'(bus.class_idx), 32'(exp_idx));
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ":rd_en0"}, 32'(bus.rd_en), 32'd0);
    chk({tag, ":rd_addr0"}, 32'(bus.rd_addr), 32'd0);
    chk({tag, ":busy0"}, 32'(bus.busy), 32'd0);
    chk({tag, ":done0"}, 32'(bus.done), 32'd0);
    chk({tag, ":idx0"}, 32'(bus.class_idx), 32'd0);
    chk({tag, ":score0"}, 32'(bus.class_score), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] t1 [NC];
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    bus.start  = 1'b1;
    bus.rd_gnt = 1'b1;
    t1 = '{16'd1, 16'd2, 16'd3, 16'h7FFF, 16'hFFFF, 16'd0, 16'd5, 16'd6, 16'd7, 16'd8};
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    bus.start = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    chk("reset:idle_after", 32'(bus.busy), 32'd0);

    // T1 directed maximum
    for (int i = 0; i < NC; i++) mem[i] = t1[i];
    classify("T1", 0, 1'b0);

    // T2 all negative
    for (int i = 0; i < NC; i++) mem[i] = 16'(-8 - i);
    classify("T2", 0, 1'b0);

    // T3 tie keeps lowest index
    for (int i = 0; i < NC; i++) mem[i] = 16'd0;
    mem[2] = 16'h1000;
    mem[7] = 16'h1000;
    classify("T3", 0, 1'b0);

    // T4 alternating grant
    for (int i = 0; i < NC; i++) mem[i] = t1[i];
    classify("T4", 1, 1'b0);

    // T5 start while busy is ignored
    for (int i = 0; i < NC; i++) mem[i] = 16'(-3 * i + 4);
    classify("T5", 0, 1'b1);

    // T6 reset mid-scan; stale returns carry 0x7FFF that must not leak into the rescan
    for (int i = 0; i < NC; i++) mem[i] = 16'd0;
    mem[4] = 16'h7FFF;
    mem[5] = 16'h7FFF;
    bus.rd_gnt = 1'b1;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    chk_zero_outputs("T6");
    #1;
    rst = 1'b1;
    for (int i = 0; i < NC; i++) mem[i] = 16'($urandom_range(0, 32766)) - 16'd16384;
    classify("T6", 0, 1'b0);

    // randomized scans: wide values, then narrow values to provoke ties
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NC; i++) begin
        if (r % 2 == 0) mem[i] = 16'($urandom());
        else            mem[i] = 16'($urandom_range(0, 7)) - 16'd4;
      end
      classify("RND", (r % 3 == 0) ? 1 : 2, 1'(r % 4 == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
